duc_cfg_ctrl: RTL
=================

# duc_cfg_ctrl

Configuration and sequencing controller for the three-stage 2x-interpolator DUC chain. It holds a host-writable shadow coefficient bank and bypass mask, and gates the DUC input handshake. It tracks in-flight output samples and swaps the shadow bank into the active bank only once the chain has fully drained, so no output sample is ever produced from a mix of old and new configuration. It sits between the sample source and the DUC input, with its coefficient and bypass outputs driving the three interpolator stages.

## Interface
- COEFF_WIDTH, 16: width of one coefficient word.
- N_TAPS, 40: coefficients per interpolator stage (both polyphase halves, index 0 = MSB slice).
- CNT_W, 8: width of the in-flight sample counter.
- RST_BYPASS, 3'b111: bypass mask loaded at reset.

- clk  in  1  clock.
- arst_n  in  1  reset, synchronous, active-low.
- cfg_wr_valid  in  1  coefficient write request.
- cfg_wr_ready  out  1  write accepted when high with cfg_wr_valid.
- cfg_wr_stage  in  2  target stage 0..2.
- cfg_wr_idx  in  6  tap index 0..N_TAPS-1.
- cfg_wr_data  in  COEFF_WIDTH  signed coefficient.
- cfg_bypass  in  3  new bypass mask, sampled with cfg_commit.
- cfg_commit  in  1  single-cycle request to apply the shadow bank and bypass mask.
- cfg_busy  out  1  high in DRAIN and APPLY.
- cfg_err  out  3  sticky errors: [0] bad write address, [1] commit while busy, [2] credit underflow.
- cfg_err_clr  in  1  clears cfg_err.
- up_valid_in  in  1  upstream sample valid.
- up_ready_out  out  1  upstream ready.
- duc_valid_out  out  1  valid to DUC src_valid_in.
- duc_ready_in  in  1  from DUC src_ready_out.
- duc_dst_fire  in  1  DUC dst_valid_out & dst_ready_in.
- coeffs_o  out  3*N_TAPS*COEFF_WIDTH  active bank; stage s occupies slice s.
- bypass_o  out  3  active bypass mask to the interpolators.
- inflight_o  out  CNT_W  current in-flight output count.

## Operation
- States: RUN, DRAIN, APPLY. Reset state is RUN.
- Shadow bank:
  - Written when cfg_wr_valid & cfg_wr_ready.
  - cfg_wr_ready = (state != APPLY).
  - If stage == 3 or idx >= N_TAPS, the write is dropped and cfg_err[0] is set.
  - Writes are permitted in RUN and DRAIN and never affect coeffs_o directly.
- Gain per input sample: G = 1 << (number of zero bits in bypass_o), range 1..8.
- Input gating:
  - headroom = (inflight <= 2^CNT_W-1-8).
  - duc_valid_out = up_valid_in & (state==RUN) & headroom.
  - up_ready_out = duc_ready_in & (state==RUN) & headroom.
  - Sample data is wired straight through and does not pass this block.
- Credit counter update:
  - On input fire, inflight += G.
  - On duc_dst_fire, inflight -= 1.
  - On both in the same cycle, inflight += G-1.
  - If duc_dst_fire arrives with inflight == 0, the counter holds at 0 and cfg_err[2] is set.
- RUN:
  - cfg_commit latches cfg_bypass into a pending register and moves to DRAIN.
  - An input fire in the commit cycle is still accepted and is counted with the old G.
- DRAIN:
  - Input is blocked.
  - When inflight == 0, move to APPLY.
  - Duration is unbounded: the state waits for downstream to consume all samples.
- APPLY:
  - Takes one cycle.
  - Active bank <= shadow bank and bypass_o <= pending mask.
  - Then return to RUN.
- cfg_commit in DRAIN or APPLY is ignored and sets cfg_err[1].
- Error handling:
  - cfg_err bits are sticky.
  - cfg_err_clr clears all bits.
  - An error event in the same cycle as cfg_err_clr wins (the bit stays set).
- Reset values:
  - state RUN; inflight 0; shadow and active banks all zero; bypass_o and pending = RST_BYPASS.
  - cfg_err 0; cfg_busy 0.
  - cfg_wr_ready 1.
  - duc_valid_out and up_ready_out follow their equations with state RUN.
- Reset asserted mid-DRAIN or mid-APPLY aborts the swap and restores reset values. The DUC must be reset together with this block.

## Timing
- All state, counter and bank updates are registered on the rising edge of clk. Gating outputs are combinational from state, inflight and the handshake inputs.
- Commit at cycle t with inflight 0 after cycle t:
  - DRAIN at t+1.
  - APPLY at t+2.
  - New coeffs_o and bypass_o visible, and RUN, at t+3; first new-config input can fire at t+3.
- Commit at cycle t with inflight N:
  - APPLY occurs in the cycle after the N-th subsequent duc_dst_fire.
- cfg_busy is high exactly in the DRAIN and APPLY cycles.
- A write at cycle t is visible in the shadow bank at t+1. A write in the same cycle as cfg_commit is included in the swap.

## Test plan
- Reset, then check bypass_o=3'b111, coeffs_o=0, inflight_o=0, cfg_busy=0, up_ready_out=duc_ready_in.
- Write stage1 idx5=16'h1234, commit with cfg_bypass=3'b000 and idle chain. Check cfg_busy for 2 cycles, then coeffs_o stage1 tap5=16'h1234 and bypass_o=0 at t+3, with no other taps changed.
- With bypass_o=3'b000, fire 3 inputs, then commit. Check inflight_o=24 and up_ready_out=0. After 23 dst fires, bypass_o is unchanged; after the 24th, APPLY follows next cycle.
- Hold duc_dst_fire low and stream inputs with bypass_o=3'b000 and CNT_W=8. Check inflight stops at 248 (headroom fails) and up_ready_out=0.
- Write to stage 3, then idx 40, then commit while in DRAIN. Check cfg_err=3'b011, shadow unchanged, and cfg_err_clr returns it to 0.
- Pulse duc_dst_fire with inflight 0: check cfg_err[2]=1 and inflight stays 0. Assert arst_n=0 mid-DRAIN: check all outputs return to reset values next cycle.

Source files
------------

// File: rtl/duc_cfg_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | duc_cfg_ctrl_if : host config bus, sample gating and DUC config outputs     |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

interface duc_cfg_ctrl_if #(
  parameter int COEFF_WIDTH = 16,
  parameter int N_TAPS      = 40,
  parameter int CNT_W       = 8
);
  logic                              cfg_wr_valid;
  logic                              cfg_wr_ready;
  logic [1:0]                        cfg_wr_stage;
  logic [5:0]                        cfg_wr_idx;
  logic [COEFF_WIDTH-1:0]            cfg_wr_data;
  logic [2:0]                        cfg_bypass;
  logic                              cfg_commit;
  logic                              cfg_busy;
  logic [2:0]                        cfg_err;
  logic                              cfg_err_clr;
  logic                              up_valid_in;
  logic                              up_ready_out;
  logic                              duc_valid_out;
  logic                              duc_ready_in;
  logic                              duc_dst_fire;
  logic [3*N_TAPS*COEFF_WIDTH-1:0]   coeffs_o;
  logic [2:0]                        bypass_o;
  logic [CNT_W-1:0]                  inflight_o;

  modport slave (
    input  cfg_wr_valid, cfg_wr_stage, cfg_wr_idx, cfg_wr_data, cfg_bypass,
    input  cfg_commit, cfg_err_clr, up_valid_in, duc_ready_in, duc_dst_fire,
    output cfg_wr_ready, cfg_busy, cfg_err, up_ready_out, duc_valid_out,
    output coeffs_o, bypass_o, inflight_o
  );

  modport master (
    output cfg_wr_valid, cfg_wr_stage, cfg_wr_idx, cfg_wr_data, cfg_bypass,
    output cfg_commit, cfg_err_clr, up_valid_in, duc_ready_in, duc_dst_fire,
    input  cfg_wr_ready, cfg_busy, cfg_err, up_ready_out, duc_valid_out,
    input  coeffs_o, bypass_o, inflight_o
  );
endinterface

`default_nettype wire

// File: rtl/duc_cfg_ctrl.sv
// +----------------------------------------------------------------------------+
// | duc_cfg_ctrl : shadow/active coefficient banks with drain-then-swap commit  |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module duc_cfg_ctrl #(
  parameter int         COEFF_WIDTH = 16,
  parameter int         N_TAPS      = 40,
  parameter int         CNT_W       = 8,
  parameter logic [2:0] RST_BYPASS  = 3'b111
) (
  input  wire logic         clk,
  input  wire logic         arst_n,
  duc_cfg_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } state_t;

  localparam int C_HEADROOM_MAX = (1 << CNT_W) - 1 - 8;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_inflight;
  logic [2:0]             r_bypass;
  logic [2:0]             r_pending;
  logic [2:0]             r_err;
  logic [COEFF_WIDTH-1:0] r_shadow [3][N_TAPS];
  logic [COEFF_WIDTH-1:0] r_active [3][N_TAPS];

  logic                   w_run;
  logic                   w_headroom;
  logic                   w_in_fire;
  logic [1:0]             w_zeros;
  logic [3:0]             w_gain;
  logic [CNT_W-1:0]       w_inflight_nxt;
  logic                   w_underflow;
  logic                   w_wr_fire;
  logic                   w_addr_ok;
  logic [2:0]             w_err_set;
  logic [3*N_TAPS*COEFF_WIDTH-1:0] w_coeffs;

  assign w_run      = (r_state == RUN);
  assign w_headroom = (r_inflight <= CNT_W'(C_HEADROOM_MAX));
  assign w_in_fire  = bus.up_valid_in & bus.duc_ready_in & w_run & w_headroom;

  // Every non-bypassed stage doubles the output samples per input sample.
  assign w_zeros = {1'b0, ~r_bypass[0]} + {1'b0, ~r_bypass[1]} + {1'b0, ~r_bypass[2]};
  assign w_gain  = 4'd1 << w_zeros;

  always_comb begin
    w_underflow    = 1'b0;
    w_inflight_nxt = r_inflight;
    if (w_in_fire && bus.duc_dst_fire) begin
      w_inflight_nxt = r_inflight + CNT_W'(w_gain) - CNT_W'(1);
    end else if (w_in_fire) begin
      w_inflight_nxt = r_inflight + CNT_W'(w_gain);
    end else if (bus.duc_dst_fire) begin
      if (r_inflight == '0) begin
        w_underflow = 1'b1;
      end else begin
        w_inflight_nxt = r_inflight - CNT_W'(1);
      end
    end
  end

  assign w_wr_fire = bus.cfg_wr_valid & bus.cfg_wr_ready;
  assign w_addr_ok = (bus.cfg_wr_stage != 2'd3) && (bus.cfg_wr_idx < 6'(N_TAPS));
  assign w_err_set = {w_underflow, bus.cfg_commit & ~w_run, w_wr_fire & ~w_addr_ok};

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state    <= RUN;
      r_inflight <= '0;
      r_bypass   <= RST_BYPASS;
      r_pending  <= RST_BYPASS;
      r_err      <= 3'b000;
      for (int s = 0; s < 3; s++) begin
        for (int t = 0; t < N_TAPS; t++) begin
          r_shadow[s][t] <= '0;
          r_active[s][t] <= '0;
        end
      end
    end else begin
      r_inflight <= w_inflight_nxt;
      r_err      <= (bus.cfg_err_clr ? 3'b000 : r_err) | w_err_set;
      if (w_wr_fire && w_addr_ok) begin
        r_shadow[bus.cfg_wr_stage][bus.cfg_wr_idx] <= bus.cfg_wr_data;
      end
      case (r_state)
        RUN: begin
          if (bus.cfg_commit) begin
            r_pending <= bus.cfg_bypass;
            r_state   <= DRAIN;
          end
        end
        // Look at the next count so APPLY lands right after the last output fires.
        DRAIN: begin
          if (w_inflight_nxt == '0) begin
            r_state <= APPLY;
          end
        end
        APPLY: begin
          r_active <= r_shadow;
          r_bypass <= r_pending;
          r_state  <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Stage s sits at slice s counted from the LSB; within a stage tap 0 is the MSB slice.
  for (genvar s = 0; s < 3; s++) begin : g_stage
    for (genvar t = 0; t < N_TAPS; t++) begin : g_tap
      assign w_coeffs[(s*N_TAPS + (N_TAPS-1-t))*COEFF_WIDTH +: COEFF_WIDTH] = r_active[s][t];
    end
  end

  assign bus.coeffs_o      = w_coeffs;
  assign bus.bypass_o      = r_bypass;
  assign bus.inflight_o    = r_inflight;
  assign bus.cfg_err       = r_err;
  assign bus.cfg_busy      = ~w_run;
  assign bus.cfg_wr_ready  = (r_state != APPLY);
  assign bus.duc_valid_out = bus.up_valid_in & w_run & w_headroom;
  assign bus.up_ready_out  = bus.duc_ready_in & w_run & w_headroom;

endmodule

`default_nettype wire
